// File: rtl/cabs_peak_find.sv
// Frame peak search behind the complex-magnitude stage: tracks max, its index and the sum per frame.
// Valid/SOF are delayed internally to line up with the magnitude pipeline output.
module cabs_peak_find #(
   parameter int unsigned LATENCY   = 14,
   parameter int unsigned FRAME_LEN = 1024,
   parameter int unsigned IDX_W     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [33:0]           mag,
   output logic                  peak_valid,
   output logic [33:0]           peak_mag,
   output logic [IDX_W-1:0]      peak_idx,
   output logic [34+IDX_W-1:0]   peak_sum,
   output logic                  frame_err
);

   localparam int unsigned MAG_W = 34;
   localparam int unsigned SUM_W = MAG_W + IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state;
   logic [LATENCY-1:0] dv_sr;
   logic [LATENCY-1:0] dsof_sr;
   logic [MAG_W-1:0]   max_r;
   logic [IDX_W-1:0]   max_idx_r;
   logic [IDX_W-1:0]   cnt_r;
   logic [SUM_W-1:0]   sum_r;

   logic               dv_c;
   logic               dsof_c;
   logic               take_c;
   logic [SUM_W-1:0]   sum_nxt_c;
   logic [MAG_W-1:0]   max_nxt_c;
   logic [IDX_W-1:0]   idx_nxt_c;

   // Running values including the sample currently on mag; strict compare keeps the earliest peak.
   always_comb begin
      dv_c      = dv_sr[LATENCY-1];
      dsof_c    = dsof_sr[LATENCY-1];
      take_c    = mag > max_r;
      sum_nxt_c = sum_r + SUM_W'(mag);
      max_nxt_c = take_c ? mag : max_r;
      idx_nxt_c = take_c ? cnt_r : max_idx_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dv_sr      <= '0;
         dsof_sr    <= '0;
         max_r      <= '0;
         max_idx_r  <= '0;
         cnt_r      <= '0;
         sum_r      <= '0;
         peak_valid <= 1'b0;
         peak_mag   <= '0;
         peak_idx   <= '0;
         peak_sum   <= '0;
         frame_err  <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;

         dv_sr[0]   <= in_valid;
         dsof_sr[0] <= in_sof & in_valid;
         for (int i = 1; i < int'(LATENCY); i++) begin
            dv_sr[i]   <= dv_sr[i-1];
            dsof_sr[i] <= dsof_sr[i-1];
         end

         if (dv_c) begin
            if (dsof_c) begin
               // A SOF always starts a fresh frame; arriving mid-frame it also aborts the old one.
               max_r     <= mag;
               max_idx_r <= '0;
               sum_r     <= SUM_W'(mag);
               cnt_r     <= IDX_W'(1);
               frame_err <= (state == ACCUM);
               state     <= ACCUM;
            end else if (state == ACCUM) begin
               if (cnt_r == LAST_IDX) begin
                  peak_mag   <= max_nxt_c;
                  peak_idx   <= idx_nxt_c;
                  peak_sum   <= sum_nxt_c;
                  peak_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  max_r     <= max_nxt_c;
                  max_idx_r <= idx_nxt_c;
                  sum_r     <= sum_nxt_c;
                  cnt_r     <= cnt_r + IDX_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cabs_peak_find.sv
// Scoreboard bench for cabs_peak_find: small-frame instance for function/timing, 1024-frame instance for sum width.
module tb_cabs_peak_find;

   localparam int unsigned LAT = 14;
   localparam int unsigned FL  = 8;
   localparam int unsigned IW  = 10;
   localparam int unsigned BFL = 1024;
   localparam logic [33:0] BMAX = 34'h3_FFFF_FFFF;

   typedef logic [33:0] frame_t [8];
   typedef struct {
      logic [33:0]   m;
      logic [IW-1:0] idx;
      logic [43:0]   s;
      int unsigned   at;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // small instance
   logic          in_valid, in_sof;
   logic [33:0]   mag_src, mag;
   logic          peak_valid, frame_err;
   logic [33:0]   peak_mag;
   logic [IW-1:0] peak_idx;
   logic [43:0]   peak_sum;

   // large instance
   logic          b_valid, b_sof;
   logic [33:0]   b_mag;
   logic          b_peak_valid, b_frame_err;
   logic [33:0]   b_peak_mag;
   logic [IW-1:0] b_peak_idx;
   logic [43:0]   b_peak_sum;

   // stand-in for the magnitude stage latency
   logic [33:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= mag_src;
      for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
   end
   assign mag = mpipe[LAT-1];

   cabs_peak_find #(.LATENCY(LAT), .FRAME_LEN(FL), .IDX_W(IW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .mag(mag),
      .peak_valid(peak_valid), .peak_mag(peak_mag), .peak_idx(peak_idx),
      .peak_sum(peak_sum), .frame_err(frame_err)
   );

   cabs_peak_find #(.LATENCY(LAT), .FRAME_LEN(BFL), .IDX_W(IW)) u_big (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_sof(b_sof), .mag(b_mag),
      .peak_valid(b_peak_valid), .peak_mag(b_peak_mag), .peak_idx(b_peak_idx),
      .peak_sum(b_peak_sum), .frame_err(b_frame_err)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   int unsigned err_q[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   exp_t        mon_e;
   int unsigned mon_at;
   always @(negedge clk) begin
      if (peak_valid === 1'b1) begin
         if (exp_q.size() == 0) check_val("unexpected_peak_valid", 64'd1, 64'd0);
         else begin
            mon_e = exp_q.pop_front();
            check_val("peak_cycle", 64'(cyc), 64'(mon_e.at));
            check_val("peak_mag", 64'(peak_mag), 64'(mon_e.m));
            check_val("peak_idx", 64'(peak_idx), 64'(mon_e.idx));
            check_val("peak_sum", 64'(peak_sum), 64'(mon_e.s));
         end
      end
      if (frame_err === 1'b1) begin
         if (err_q.size() == 0) check_val("unexpected_frame_err", 64'd1, 64'd0);
         else begin
            mon_at = err_q.pop_front();
            check_val("frame_err_cycle", 64'(cyc), 64'(mon_at));
         end
      end
   end

   task automatic send(input logic sof, input logic [33:0] m, output int unsigned at);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      mag_src  = m;
      at       = cyc;
   endtask

   // idle cycles carry junk mag and random SOF, both of which must be ignored
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'($urandom_range(0, 1));
         mag_src  = 34'($urandom);
      end
   endtask

   task automatic drive_frame(input frame_t v, input int n, input int maxgap,
                              input bit done, output int unsigned first_at);
      logic [33:0]   mx;
      logic [IW-1:0] ix;
      logic [43:0]   s;
      int unsigned   at;
      exp_t          e;
      mx = '0; ix = '0; s = '0;
      first_at = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0 && maxgap > 0) idle(int'($urandom_range(0, maxgap)));
         send(i == 0, v[i], at);
         if (i == 0) first_at = at;
         if (i == 0 || v[i] > mx) begin
            mx = v[i];
            ix = IW'(i);
         end
         s = s + 44'(v[i]);
      end
      if (done) begin
         e.m = mx; e.idx = ix; e.s = s; e.at = at + LAT + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_mag"}, 64'(peak_mag), 64'd0);
      check_val({tag, "_idx"}, 64'(peak_idx), 64'd0);
      check_val({tag, "_sum"}, 64'(peak_sum), 64'd0);
      check_val({tag, "_valid"}, 64'(peak_valid), 64'd0);
      check_val({tag, "_err"}, 64'(frame_err), 64'd0);
   endtask

   frame_t      f;
   int unsigned fa;
   int unsigned b_last;
   logic [43:0] b_sum;
   bit          b_seen;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; mag_src = '0;
      b_valid = 1'b0; b_sof = 1'b0; b_mag = BMAX;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      idle(3);

      // single contiguous frame
      f = '{34'd5, 34'd9, 34'd3, 34'd9, 34'd1, 34'd2, 34'd0, 34'd4};
      drive_frame(f, 8, 0, 1'b1, fa);
      idle(20);

      // same frame with random valid gaps
      drive_frame(f, 8, 3, 1'b1, fa);
      idle(20);

      // back-to-back frames; second frame's tie on every sample keeps index 0
      f = '{34'd12, 34'd3, 34'd30, 34'd30, 34'd1, 34'd0, 34'd29, 34'd2};
      drive_frame(f, 8, 0, 1'b1, fa);
      f = '{34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7};
      drive_frame(f, 8, 0, 1'b1, fa);
      idle(25);
      check_val("hold_peak_mag", 64'(peak_mag), 64'd7);
      check_val("hold_peak_sum", 64'(peak_sum), 64'd56);

      // early SOF at sample 5 aborts the frame and restarts on that sample
      f = '{34'd50, 34'd60, 34'd70, 34'd80, 34'd90, 34'd0, 34'd0, 34'd0};
      drive_frame(f, 5, 0, 1'b0, fa);
      f = '{34'd40, 34'd6, 34'd40, 34'd1, 34'd0, 34'd3, 34'd5, 34'd4};
      drive_frame(f, 8, 0, 1'b1, fa);
      err_q.push_back(fa + LAT + 1);
      idle(20);

      // reset mid-frame drops in-flight samples and clears outputs
      f = '{34'd100, 34'd200, 34'd300, 34'd400, 34'd0, 34'd0, 34'd0, 34'd0};
      drive_frame(f, 4, 0, 1'b0, fa);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("post_reset");
      idle(20);
      check_zero_outputs("post_reset_idle");
      f = '{34'd3, 34'd1, 34'd4, 34'd1, 34'd5, 34'd9, 34'd2, 34'd6};
      drive_frame(f, 8, 0, 1'b1, fa);
      idle(20);

      // full-length frame at maximum magnitude
      b_sum = '0;
      for (int i = 0; i < int'(BFL); i++) begin
         @(negedge clk);
         b_valid = 1'b1;
         b_sof   = (i == 0);
         b_last  = cyc;
         b_sum   = b_sum + 44'(BMAX);
      end
      @(negedge clk);
      b_valid = 1'b0; b_sof = 1'b0;
      b_seen = 1'b0;
      for (int k = 0; k < 40 && !b_seen; k++) begin
         if (b_peak_valid === 1'b1) begin
            b_seen = 1'b1;
            check_val("big_peak_cycle", 64'(cyc), 64'(b_last + LAT + 1));
            check_val("big_peak_mag", 64'(b_peak_mag), 64'(BMAX));
            check_val("big_peak_idx", 64'(b_peak_idx), 64'd0);
            check_val("big_peak_sum", 64'(b_peak_sum), 64'(b_sum));
         end else begin
            @(negedge clk);
         end
      end
      check_val("big_peak_seen", 64'(b_seen), 64'd1);
      check_val("big_frame_err", 64'(b_frame_err), 64'd0);

      check_val("pending_peaks", 64'(exp_q.size()), 64'd0);
      check_val("pending_errs", 64'(err_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
